// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and FSM encoding for the PWM capture path
package pwm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARM     = 2'd1,
    CAP_MEASURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - input synchronizer chain with single-cycle rise/fall strobes
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Both strobes come from the same flop pair, so rise and fall see equal latency.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high-time of an external pulse train
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             chosen_clk,
  input  logic             rst_n,
  input  logic             capture_en,
  input  logic             i_pwm_in,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] period_cap,
  output logic [WIDTH-1:0] high_cap,
  output logic             cap_valid,
  output logic             irq_flag,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_TOP = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (chosen_clk),
    .rst_n (rst_n),
    .din   (i_pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_lat_q, high_lat_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             cap_valid_q, cap_valid_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             irq_set_q, irq_set_d;
  logic             ovf_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_lat_d  = high_lat_q;
    period_d    = period_q;
    high_d      = high_q;
    cap_valid_d = 1'b0;
    irq_set_d   = 1'b0;
    ovf_set     = 1'b0;

    if (!capture_en) begin
      state_d    = CAP_IDLE;
      cnt_d      = '0;
      high_lat_d = '0;
    end else begin
      case (state_q)
        CAP_IDLE: begin
          cnt_d      = '0;
          high_lat_d = '0;
          state_d    = CAP_ARM;
        end
        CAP_ARM: begin
          if (rise) begin
            cnt_d      = CNT_ONE;
            high_lat_d = '0;
            state_d    = CAP_MEASURE;
          end
        end
        CAP_MEASURE: begin
          if (rise) begin
            period_d    = cnt_q;
            high_d      = high_lat_q;
            cap_valid_d = 1'b1;
            irq_set_d   = 1'b1;
            cnt_d       = CNT_ONE;
            high_lat_d  = '0;
          end else if (cnt_q == CNT_TOP) begin
            // Partial measurement is dropped; rearm on the next rising edge.
            ovf_set    = 1'b1;
            irq_set_d  = 1'b1;
            cnt_d      = '0;
            high_lat_d = '0;
            state_d    = CAP_ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) high_lat_d = cnt_q;
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end

    // A clear in the set cycle or in the cycle the flag first shows is overridden.
    irq_d = irq_set_d | irq_set_q | (irq_q & ~irq_clr);
    ovf_d = ovf_set | (ovf_q & ~irq_clr);
  end

  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CAP_IDLE;
      cnt_q       <= '0;
      high_lat_q  <= '0;
      period_q    <= '0;
      high_q      <= '0;
      cap_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
      irq_set_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_lat_q  <= high_lat_d;
      period_q    <= period_d;
      high_q      <= high_d;
      cap_valid_q <= cap_valid_d;
      irq_q       <= irq_d;
      ovf_q       <= ovf_d;
      irq_set_q   <= irq_set_d;
    end
  end

  assign period_cap = period_q;
  assign high_cap   = high_q;
  assign cap_valid  = cap_valid_q;
  assign irq_flag   = irq_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed vectors and corner sequences for pwm_capture
module tb_pwm_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         capture_en = 1'b0;
  logic         pwm = 1'b0;
  logic         irq_clr = 1'b0;
  logic [W-1:0] period_cap, high_cap;
  logic         cap_valid, irq_flag, overflow;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .chosen_clk (clk),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .i_pwm_in   (pwm),
    .irq_clr    (irq_clr),
    .period_cap (period_cap),
    .high_cap   (high_cap),
    .cap_valid  (cap_valid),
    .irq_flag   (irq_flag),
    .overflow   (overflow)
  );

  int total = 0;
  int bad = 0;
  int cv_count = 0;
  int cap_bad = 0;
  int exp_p = 0;
  int exp_h = 0;

  always @(negedge clk) begin
    if (cap_valid === 1'b1) begin
      cv_count++;
      if (int'(period_cap) != exp_p || int'(high_cap) != exp_h) cap_bad++;
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic rearm();
    capture_en = 1'b0;
    repeat (3) @(negedge clk);
    capture_en = 1'b1;
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulses(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) begin
      pwm = 1'b1;
      repeat (high) @(negedge clk);
      pwm = 1'b0;
      repeat (period - high) @(negedge clk);
    end
  endtask

  // Closing rising edge so the last full period gets captured.
  task automatic last_edge(input int high);
    pwm = 1'b1;
    repeat (high) @(negedge clk);
    pwm = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    int period;
    int high;
    int n;
    int exp_period;
    int exp_high;
    int exp_caps;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int rst_bad;
    int base;
    int bad0;
    int prev_p;
    int prev_h;
    int found;

    tbl[0] = '{20,   5, 4, 20,   5, 4};
    tbl[1] = '{ 2,   1, 6,  2,   1, 6};
    tbl[2] = '{ 7,   3, 3,  7,   3, 3};
    tbl[3] = '{13,  12, 2, 13,  12, 2};
    tbl[4] = '{ 3,   2, 4,  3,   2, 4};
    tbl[5] = '{255, 100, 1, 255, 100, 1};

    // Reset held while the pin toggles
    rst_n = 1'b0;
    capture_en = 1'b1;
    rst_bad = 0;
    for (int i = 0; i < 20; i++) begin
      pwm = ~pwm;
      @(negedge clk);
      if (cap_valid !== 1'b0 || irq_flag !== 1'b0 || overflow !== 1'b0 ||
          period_cap !== '0 || high_cap !== '0) rst_bad++;
    end
    check("reset_outputs_zero", rst_bad, 0);
    check("reset_no_cap_valid", cv_count, 0);
    pwm = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      exp_p = tbl[v].exp_period;
      exp_h = tbl[v].exp_high;
      rearm();
      check("irq_cleared_before_vec", int'(irq_flag), 0);
      base = cv_count;
      bad0 = cap_bad;
      pulses(tbl[v].period, tbl[v].high, tbl[v].n);
      last_edge(tbl[v].high);
      check("vec_cap_count", cv_count - base, tbl[v].exp_caps);
      check("vec_cap_values_bad", cap_bad - bad0, 0);
      check("vec_period_cap", int'(period_cap), tbl[v].exp_period);
      check("vec_high_cap", int'(high_cap), tbl[v].exp_high);
      check("vec_irq_set", int'(irq_flag), 1);
      check("vec_no_overflow", int'(overflow), 0);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      @(negedge clk);
      check("vec_irq_clr", int'(irq_flag), 0);
    end

    // Overflow: input stuck high after a single rising edge
    prev_p = tbl[5].exp_period;
    prev_h = tbl[5].exp_high;
    exp_p = 10;
    exp_h = 4;
    rearm();
    base = cv_count;
    bad0 = cap_bad;
    pwm = 1'b1;
    repeat (300) @(negedge clk);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_irq", int'(irq_flag), 1);
    check("ovf_no_capture", cv_count - base, 0);
    check("ovf_period_hold", int'(period_cap), prev_p);
    check("ovf_high_hold", int'(high_cap), prev_h);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    pulses(10, 4, 1);
    last_edge(4);
    check("ovf_recover_count", cv_count - base, 1);
    check("ovf_recover_period", int'(period_cap), 10);
    check("ovf_recover_high", int'(high_cap), 4);
    check("ovf_recover_values_bad", cap_bad - bad0, 0);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", int'(overflow), 0);
    check("ovf_irq_cleared", int'(irq_flag), 0);

    // Clear colliding with a capture
    exp_p = 10;
    exp_h = 4;
    rearm();
    found = 0;
    fork
      pulses(10, 4, 3);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (cap_valid === 1'b1) begin
            irq_clr = 1'b1;
            @(negedge clk);
            irq_clr = 1'b0;
            found = 1;
            break;
          end
        end
        check("collide_cap_seen", found, 1);
        check("collide_irq_stays", int'(irq_flag), 1);
      end
    join
    pwm = 1'b0;

    // Enable dropped mid-period, then restored
    exp_p = 20;
    exp_h = 5;
    rearm();
    pulses(20, 5, 3);
    pwm = 1'b1;
    repeat (5) @(negedge clk);
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    capture_en = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_period_hold", int'(period_cap), 20);
    check("drop_high_hold", int'(high_cap), 5);
    exp_p = 12;
    exp_h = 7;
    capture_en = 1'b1;
    base = cv_count;
    bad0 = cap_bad;
    pwm = 1'b1;
    repeat (7) @(negedge clk);
    check("reen_no_cap_first_edge", cv_count - base, 0);
    check("reen_period_hold", int'(period_cap), 20);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    pwm = 1'b1;
    repeat (7) @(negedge clk);
    check("reen_cap_second_edge", cv_count - base, 1);
    check("reen_period", int'(period_cap), 12);
    check("reen_high", int'(high_cap), 7);
    check("reen_values_bad", cap_bad - bad0, 0);

    // Reset asserted mid-measurement
    pwm = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_period", int'(period_cap), 0);
    check("midrst_high", int'(high_cap), 0);
    check("midrst_irq", int'(irq_flag), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
